// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: paces signed 12-bit mixer samples out to an 8-bit R-2R DAC at one sample every DIV clocks
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   s_data/s_valid      : signed two's-complement sample and its valid strobe
//   s_ready             : registered, high while the FIFO has room
//   d0..d7              : DAC code bits, d7 is the MSB
//   underrun            : one-cycle pulse when a sample tick finds the FIFO empty
//   level               : current FIFO occupancy
//   Optional macro DAC_NOISE_SHAPE_EN adds first-order error feedback on the 12->8 bit truncation.
module dac_sample_feeder #(
    parameter int DEPTH = 4,
    parameter int DIV   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        d0,
    output logic        d1,
    output logic        d2,
    output logic        d3,
    output logic        d4,
    output logic        d5,
    output logic        d6,
    output logic        d7,
    output logic        underrun,
    output logic [3:0]  level
);
    localparam int AW = $clog2(DEPTH);
    logic [11:0]   mem_q [DEPTH];
    logic [11:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [3:0]    level_q, level_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          s_ready_q, s_ready_d;
    logic [7:0]    dac_q, dac_d;
    logic          tick, push, pop;
    logic [11:0]   u12;
    logic [7:0]    code;
`ifdef DAC_NOISE_SHAPE_EN
    logic [3:0]    err_q, err_d;
    logic [12:0]   v;
`endif
    always_comb begin
        tick = cnt_q == 16'(DIV - 1);
        push = s_valid && s_ready_q;
        pop  = tick && level_q != 4'd0;
        // adding 2048 mod 4096 is just an MSB flip
        u12  = {~mem_q[rd_q][11], mem_q[rd_q][10:0]};
`ifdef DAC_NOISE_SHAPE_EN
        v     = {1'b0, u12} + {9'd0, err_q};
        code  = v[12] ? 8'hFF : v[11:4];
        err_d = pop ? (v[12] ? 4'd0 : v[3:0]) : err_q;
`else
        code  = u12[11:4];
`endif
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        mem_d = mem_q;
        if (push)
            mem_d[wr_q] = s_data;
        wr_d      = push ? wr_q + AW'(1) : wr_q;
        rd_d      = pop ? rd_q + AW'(1) : rd_q;
        level_d   = level_q + {3'd0, push} - {3'd0, pop};
        // ready follows next-cycle occupancy so it never depends on this cycle's s_valid
        s_ready_d = level_d < 4'(DEPTH);
        dac_d     = pop ? code : dac_q;
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= 4'd0;
            cnt_q     <= 16'd0;
            s_ready_q <= 1'b0;
            dac_q     <= 8'h80;
`ifdef DAC_NOISE_SHAPE_EN
            err_q     <= 4'd0;
`endif
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            dac_q     <= dac_d;
`ifdef DAC_NOISE_SHAPE_EN
            err_q     <= err_d;
`endif
        end
    end
    assign s_ready  = s_ready_q;
    assign level    = level_q;
    assign underrun = tick && level_q == 4'd0 && !rst;
    assign {d7, d6, d5, d4, d3, d2, d1, d0} = dac_q;
endmodule

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning sample FIFO depth; legal values are 2, 4 and 8.
REQ-002 The block SHALL have parameter DIV, default 256, meaning clk cycles per output sample period; legal range is 2 to 65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port s_data, input, 12 bits: signed two's-complement mixer sample.
REQ-006 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: the FIFO can accept a sample.
REQ-008 The block SHALL have ports d0..d7, output, 1 bit each: scalar DAC code bits; d7 is the MSB; they connect directly to the R-2R DAC macro.
REQ-009 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a sample tick finds the FIFO empty.
REQ-010 The block SHALL have port level, output, 4 bits: current FIFO occupancy.

Function
REQ-011 A push SHALL occur in every cycle where s_valid=1 and s_ready=1; s_data is captured at that rising edge.
REQ-012 s_ready SHALL be registered and SHALL equal (level < DEPTH); it has no combinational path from s_valid or from the tick.
REQ-013 A tick counter SHALL count 0..DIV-1 and wrap; the tick is asserted in the cycle where the count equals DIV-1.
REQ-014 On a tick with level>0, the head sample SHALL pop and the DAC code SHALL update at the same edge; d0..d7 show the new code in the next cycle (1-cycle latency from tick).
REQ-015 On a tick with level=0, d0..d7 SHALL hold their previous value, and underrun SHALL be 1 for exactly that cycle.
REQ-016 A push to an empty FIFO in the tick cycle SHALL NOT bypass: that tick reports underrun, and the sample pops at the next tick.
REQ-017 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; no sample is lost or duplicated across the wrap.
REQ-019 Conversion to offset binary SHALL be u12 = s_data + 2048, computed mod 4096 (-2048 -> 0, 0 -> 2048, +2047 -> 4095).
REQ-020 The DAC code SHALL be the upper 8 bits of the converted value, u12[11:4] (see REQ-024 for the shaped variant).
REQ-021 Pushes while s_ready=0 SHALL be ignored by the block; the upstream holds s_data and s_valid until accepted.

Reset
REQ-022 While rst=1, the block SHALL set level=0, clear both pointers, set the tick counter to 0, set underrun=0, set s_ready=0, and set d7..d0=8'h80 (midscale, no pop).
REQ-023 Reset asserted mid-operation SHALL discard all buffered samples; s_ready SHALL rise the first cycle after rst deasserts, and the first tick follows DIV cycles later.

Configuration
REQ-024 With macro DAC_NOISE_SHAPE_EN defined, the block SHALL apply first-order error feedback:
- a 4-bit register err holds the residual and resets to 0.
- at each pop, v = u12 + err, computed as 13 bits.
- if v > 4095, the code is 8'hFF and err becomes 0.
- otherwise the code is v[11:4] and err becomes v[3:0].
- err is unchanged on underrun ticks.
REQ-025 Without DAC_NOISE_SHAPE_EN, no err register SHALL exist and the code SHALL be u12[11:4] exactly.

Verification
REQ-026 Release reset with s_valid=0 and DIV=4 -> d=0x80 constantly, and underrun pulses every 4th cycle.
REQ-027 With DIV=4, push -2048, 0, 2047 back-to-back -> codes 0x00, 0x80, 0xFF appear on successive ticks, each 1 cycle after its tick.
REQ-028 With DEPTH=4, push 6 samples with no tick -> s_ready=0 after the 4th push, level=4, and samples 5-6 are held by upstream and not lost.
REQ-029 Push into an empty FIFO exactly in the tick cycle -> underrun=1 that cycle, and the sample appears at the next tick.
REQ-030 Assert rst with level=3 -> level=0 and d=0x80 next cycle, and none of the 3 samples is ever output.
REQ-031 With DAC_NOISE_SHAPE_EN defined, push constant 0x008 (u12=2056) four times -> codes 0x80, 0x81, 0x80, 0x81 (err sequence 8, 0, 8, 0).
